serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: computes diff = a - b, LSB first, one bit per clock.
//  One 1-bit full-subtractor cell plus a borrow flip-flop replaces a WIDTH-bit ripple chain.
//  Sits beside the ripple adders in the datapath; start/busy/done handshake with the controlling FSM.
// PARAMETERS
//  WIDTH  8  operand and result width in bits (>=1)
// PORTS
//  clk         in   1      system clock, all state updates on rising edge
//  reset       in   1      synchronous, active-high; clears all state
//  start       in   1      request; sampled only in IDLE or DONE
//  a           in   WIDTH  minuend, captured on accepted start
//  b           in   WIDTH  subtrahend, captured on accepted start
//  busy        out  1      high while in RUN
//  done        out  1      one-cycle pulse; result valid from this cycle on
//  diff        out  WIDTH  a - b mod 2^WIDTH; held until next accepted start
//  borrow_out  out  1      1 when a < b unsigned; held with diff
//  overflow    out  1      signed overflow (only with SERIAL_SUB_OVF_EN; else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, diff=0, borrow_out=0, overflow=0; shift regs/counter=0.
//  FSM states IDLE, RUN, DONE.
//   IDLE: start=1 -> load a_sr<=a, b_sr<=b, borrow<=0, cnt<=0; go RUN. start=0 -> stay.
//   RUN: per cycle d=a_sr[0]^b_sr[0]^borrow;
//        borrow<=(~a_sr[0]&b_sr[0])|(~(a_sr[0]^b_sr[0])&borrow);
//        d shifts into diff_sr MSB (diff_sr shifts right); a_sr,b_sr shift right.
//        cnt==WIDTH-1 -> go DONE, else cnt<=cnt+1. start ignored (no reload, no queue).
//   DONE (exactly 1 cycle): diff<=diff_sr, borrow_out<=final borrow, done=1.
//        start=1 in DONE -> accepted as in IDLE, go RUN; else go IDLE.
//  Latency: start accepted at edge N -> done high in cycle after edge N+WIDTH;
//   back-to-back throughput one op per WIDTH+1 cycles.
//  diff/borrow_out change only on DONE entry; stable in IDLE and during next RUN.
//  Inputs a,b only sampled on accept; changing them during RUN has no effect.
//  Reset mid-RUN: abort, no done pulse, outputs cleared to 0.
//  WIDTH=1: RUN lasts one cycle; cnt width = max(1,$clog2(WIDTH)).
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined: overflow<=(a_msb!=b_msb)&&(d_msb!=a_msb), updated with diff
//   (capture a/b MSBs on accept).
//  Undefined: overflow tied 0, MSB capture logic absent.
// STRUCTURE
//  Package serial_sub_pkg: state enum {IDLE,RUN,DONE} (2-bit), SS_DEFAULT_WIDTH=8.
//  Sub-module full_subtractor (d, bout from x, y, bin; combinational) instantiated once.
//  Top holds FSM, counter, three shift registers, borrow and output registers.
// TESTING (WIDTH=8 unless stated)
//  a=0x05,b=0x03,start 1 cycle -> done 9 cycles later, diff=0x02, borrow_out=0, busy 8 cycles.
//  a=0x03,b=0x05 -> diff=0xFE, borrow_out=1; a=0x00,b=0xFF -> diff=0x01, borrow_out=1.
//  start held high continuously, a=0x10,b=0x01 -> done every 9 cycles, diff=0x0F; mid-RUN a,b
//   changes ignored.
//  Reset asserted at RUN cycle 4 -> next cycle busy=0, diff=0, no done; new op then completes normally.
//  OVF_EN: a=0x80,b=0x01 -> diff=0x7F, overflow=1; a=0x7F,b=0x01 -> overflow=0;
//   without macro overflow stays 0.
//  WIDTH=1: a=0,b=1 -> done 2 cycles after start, diff=1, borrow_out=1.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor:
//     - ss_state_e       : controller states IDLE / RUN / DONE (2-bit encoding)
//     - SS_DEFAULT_WIDTH : default operand width
//   Ports: none (package).
// ---------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int SS_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ss_state_e;

endpackage

// File: rtl/full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   One-bit combinational full subtractor: computes x - y - bin.
//   Ports:
//     x    in  1  minuend bit
//     y    in  1  subtrahend bit
//     bin  in  1  borrow in from the less significant bit
//     d    out 1  difference bit
//     bout out 1  borrow out to the more significant bit
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when y exceeds x, or when x == y and a borrow is already pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor: diff = a - b (mod 2^WIDTH),
//   processed LSB first, one bit per clock through a single full_subtractor
//   cell and a borrow flip-flop.
//
//   Optional feature: define SERIAL_SUB_OVF_EN to compute signed overflow.
//   Without it, overflow is tied to 0 and no MSB capture logic exists.
//
//   Parameters:
//     WIDTH       operand/result width in bits (>= 1)
//   Ports:
//     clk         in   1      rising-edge clock
//     reset       in   1      synchronous, active-high; clears all state
//     start       in   1      operation request (accepted in IDLE or DONE)
//     a           in   WIDTH  minuend, captured when start is accepted
//     b           in   WIDTH  subtrahend, captured when start is accepted
//     busy        out  1      high while bits are being processed (RUN)
//     done        out  1      one-cycle pulse, result valid from this cycle on
//     diff        out  WIDTH  a - b, held until the next result
//     borrow_out  out  1      1 when a < b unsigned, held with diff
//     overflow    out  1      signed overflow (0 unless SERIAL_SUB_OVF_EN)
//
//   Handshake: start is a request sampled only while busy is low (IDLE or
//   DONE); a sampled start is accepted unconditionally, so there is no
//   separate ready. start while busy is ignored, not queued. done pulses for
//   exactly one cycle WIDTH+1 cycles after acceptance; diff/borrow_out/
//   overflow change only on the edge that raises done and stay stable
//   through IDLE and the following RUN. The controller state is held in the
//   signal "state" for observation.
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ss_state_e        state;
    ss_state_e        state_next;
    logic             load;
    logic             shift;
    logic             last;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_sr_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             d_bit;
    logic             b_next;

    full_subtractor u_fs (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (b_next)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state and control ----------------
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (cnt == CNT_LAST) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign last = shift && (cnt == CNT_LAST);

    // New difference bit enters at the MSB; after WIDTH shifts the first
    // (LSB) bit has reached position 0. Written this way to stay legal for
    // WIDTH == 1.
    always_comb begin
        diff_sr_next            = diff_sr >> 1;
        diff_sr_next[WIDTH-1]   = d_bit;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr       <= '0;
            b_sr       <= '0;
            diff_sr    <= '0;
            cnt        <= '0;
            borrow     <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (shift) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            borrow  <= b_next;
            diff_sr <= diff_sr_next;
            if (last) begin
                // Result registers are loaded on the edge that enters DONE
                // so they are valid in the same cycle done is high.
                diff       <= diff_sr_next;
                borrow_out <= b_next;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    // Signed overflow: operands of different sign and the result's sign
    // differs from the minuend's. The final d_bit is the result MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (last) begin
            overflow <= (a_msb != b_msb) && (d_bit != a_msb);
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed self-checking bench for serial_subtractor: a WIDTH=8 instance
//   for the main function and a WIDTH=1 instance for the single-bit case.
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;
    logic       overflow;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow_out1;
    logic       overflow1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start1),
        .a          (a1),
        .b          (b1),
        .busy       (busy1),
        .done       (done1),
        .diff       (diff1),
        .borrow_out (borrow_out1),
        .overflow   (overflow1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Overflow is only produced when the feature is compiled in.
    function automatic logic ovf_exp(input logic v);
`ifdef SERIAL_SUB_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // One complete operation on the 8-bit instance; a/b are scrambled during
    // RUN to show they are only sampled on acceptance.
    task automatic run_op8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] exp_diff, input logic exp_borrow,
                           input logic exp_ovf);
        int lat;
        int busy_cnt;
        logic [7:0] held;
        a     = va;
        b     = vb;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"},  lat,        9);
        check({tag, "_busy_cyc"}, busy_cnt,   8);
        check({tag, "_busy_dn"},  busy,       1'b0);
        check({tag, "_diff"},     diff,       exp_diff);
        check({tag, "_borrow"},   borrow_out, exp_borrow);
        check({tag, "_ovf"},      overflow,   ovf_exp(exp_ovf));
        held = diff;
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_diff_held"},  diff, exp_diff);
    endtask

    initial begin : stimulus
        int lat;
        logic saw_done;

        reset  = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy",   busy,       1'b0);
        check("rst_done",   done,       1'b0);
        check("rst_diff",   diff,       8'h00);
        check("rst_borrow", borrow_out, 1'b0);
        check("rst_ovf",    overflow,   1'b0);
        check("rst_done1",  done1,      1'b0);

        // Basic subtractions (hand-computed)
        run_op8("op_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op8("op_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op8("op_00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
        run_op8("op_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op8("op_7f_01", 8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0);

        // Back-to-back with start held high: one result every 9 cycles
        a     = 8'h10;
        b     = 8'h01;
        start = 1'b1;
        @(negedge clk);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_lat0",  lat,  9);
        check("b2b_diff0", diff, 8'h0F);
        @(negedge clk);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 1) begin
                a = 8'h55;
                b = 8'hAA;
            end
            if (lat == 5) begin
                a = 8'h10;
                b = 8'h01;
            end
            @(negedge clk);
            lat++;
        end
        check("b2b_lat1",  lat,  9);
        check("b2b_diff1", diff, 8'h0F);
        start = 1'b0;
        @(negedge clk);
        check("b2b_idle_busy", busy, 1'b0);
        check("b2b_idle_done", done, 1'b0);

        // Reset during RUN cycle 4: aborts, clears outputs, no done
        a     = 8'hAA;
        b     = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_pre", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy",   busy,       1'b0);
        check("mid_done",   done,       1'b0);
        check("mid_diff",   diff,       8'h00);
        check("mid_borrow", borrow_out, 1'b0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("mid_no_done", saw_done, 1'b0);
        run_op8("op_20_05", 8'h20, 8'h05, 8'h1B, 1'b0, 1'b0);

        // WIDTH=1 instance: 0 - 1 = 1 with borrow; signed -1 is not reachable
        // from 0 - (-1), so overflow is set when enabled
        a1     = 1'b0;
        b1     = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat    = 1;
        while (done1 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("w1_latency", lat,         2);
        check("w1_diff",    diff1,       1'b1);
        check("w1_borrow",  borrow_out1, 1'b1);
        check("w1_ovf",     overflow1,   ovf_exp(1'b1));
        @(negedge clk);
        check("w1_done_pulse", done1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
